// File: rtl/icache_ctrl.sv
// ----------------------------------------------------------------------------
// icache_ctrl: direct-mapped instruction cache controller between the IFQ fetch
// port and main memory. Serves 16-byte lines: one cycle after ifq_ren on a hit,
// or after a 4-beat memory refill on a miss. Owns the tag, valid and data arrays.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   ifq_pcin          fetch byte address (bits [3:0] ignored)
//   ifq_ren           line read request (ignored while ifq_stall is high)
//   ifq_abort         cancel the outstanding request (branch redirect)
//   ifq_dout          128-bit line, word k in [32k+31:32k]
//   ifq_dout_valid    one-cycle pulse qualifying ifq_dout
//   ifq_stall         controller busy
//   cache_flush       invalidate all lines
//   mem_req/mem_addr  refill request and line address, held until mem_gnt
//   mem_gnt           memory accepted the request
//   mem_rdata/rvalid  refill beats, exactly 4 per grant
//   hit_cnt/miss_cnt  saturating lookup counters (only with ICACHE_PERF_EN)
//
// Configuration macro: ICACHE_PERF_EN adds the hit_cnt/miss_cnt ports.
// ----------------------------------------------------------------------------
module icache_ctrl #(
   parameter int unsigned NUM_LINES = 64,
   parameter int unsigned MEM_AW    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       ifq_pcin,
   input  logic              ifq_ren,
   input  logic              ifq_abort,
   output logic [127:0]      ifq_dout,
   output logic              ifq_dout_valid,
   output logic              ifq_stall,
   input  logic              cache_flush,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_rvalid
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int unsigned IDX_W  = $clog2(NUM_LINES);
   localparam int unsigned LA_W   = 28;              // line address = pcin[31:4]
   localparam int unsigned TAG_W  = LA_W - IDX_W;
   localparam int unsigned LINE_W = 128;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_REQ, S_FILL, S_RESP, S_DRAIN
   } state_e;

   state_e              state_q, state_d;
   logic [LA_W-1:0]     pc_q, pc_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic                flush_pend_q, flush_pend_d;
   logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;

   logic [TAG_W-1:0]    tag_arr_q  [NUM_LINES];
   logic [LINE_W-1:0]   data_arr_q [NUM_LINES];

   logic [IDX_W-1:0]    pcin_idx_c, pc_idx_c;
   logic [TAG_W-1:0]    pc_tag_c;
   logic                hit_c, arr_we_c, dout_valid_c, stall_c, mem_req_c;
   logic                hit_inc_c, miss_inc_c;
   logic                unused_c;

   assign pcin_idx_c = ifq_pcin[IDX_W+3:4];
   assign pc_idx_c   = pc_q[IDX_W-1:0];
   assign pc_tag_c   = pc_q[LA_W-1:IDX_W];
   assign unused_c   = ^ifq_pcin[3:0];

   // A flush arriving during the lookup cycle forces a miss.
   assign hit_c = valid_q[pc_idx_c] && (tag_arr_q[pc_idx_c] == pc_tag_c) && !cache_flush;

   // Next-state and output decode.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      line_d       = line_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      flush_pend_d = flush_pend_q;
      mem_addr_d   = mem_addr_q;
      arr_we_c     = 1'b0;
      dout_valid_c = 1'b0;
      stall_c      = 1'b0;
      mem_req_c    = 1'b0;
      hit_inc_c    = 1'b0;
      miss_inc_c   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cache_flush) valid_d = '0;
            if (ifq_ren) begin
               pc_d    = ifq_pcin[31:4];
               line_d  = data_arr_q[pcin_idx_c];
               state_d = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (cache_flush) valid_d = '0;
            stall_c = !hit_c;
            if (ifq_abort) begin
               state_d = S_IDLE;
            end else if (hit_c) begin
               dout_valid_c = 1'b1;
               hit_inc_c    = 1'b1;
               // Back-to-back hit: accept the next request in the same cycle.
               if (ifq_ren) begin
                  pc_d   = ifq_pcin[31:4];
                  line_d = data_arr_q[pcin_idx_c];
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               miss_inc_c = 1'b1;
               mem_addr_d = MEM_AW'({pc_q, 4'h0});
               state_d    = S_REQ;
            end
         end

         S_REQ: begin
            stall_c      = 1'b1;
            mem_req_c    = 1'b1;
            flush_pend_d = flush_pend_q | cache_flush;
            if (mem_gnt) begin
               cnt_d   = '0;
               state_d = ifq_abort ? S_DRAIN : S_FILL;
            end else if (ifq_abort) begin
               state_d = S_IDLE;
            end
         end

         S_FILL, S_DRAIN: begin
            stall_c      = 1'b1;
            flush_pend_d = flush_pend_q | cache_flush;
            if (mem_rvalid) begin
               for (int k = 0; k < 4; k++) begin
                  if (cnt_q == 2'(k)) line_d[32*k +: 32] = mem_rdata;
               end
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  // Last beat: commit the line whether or not it was aborted.
                  arr_we_c          = 1'b1;
                  valid_d[pc_idx_c] = 1'b1;
                  state_d = (state_q == S_FILL && !ifq_abort) ? S_RESP : S_IDLE;
               end else if (ifq_abort) begin
                  state_d = S_DRAIN;
               end
            end else if (ifq_abort) begin
               state_d = S_DRAIN;
            end
         end

         S_RESP: begin
            stall_c      = 1'b1;
            dout_valid_c = !ifq_abort;
            flush_pend_d = flush_pend_q | cache_flush;
            state_d      = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // Deferred flush lands on the return to IDLE, after any line write above.
      if (state_d == S_IDLE && flush_pend_d) begin
         valid_d      = '0;
         flush_pend_d = 1'b0;
      end
   end

   // Control state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         line_q       <= '0;
         cnt_q        <= '0;
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         line_q       <= line_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         flush_pend_q <= flush_pend_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   // Tag and data arrays (not reset; qualified by valid_q).
   always_ff @(posedge clk) begin
      if (arr_we_c && !reset) begin
         tag_arr_q[pc_idx_c]  <= pc_tag_c;
         data_arr_q[pc_idx_c] <= line_d;
      end
   end

   assign ifq_dout       = line_q;
   assign ifq_dout_valid = dout_valid_c;
   assign ifq_stall      = stall_c;
   assign mem_req        = mem_req_c;
   assign mem_addr       = mem_addr_q;

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   // Saturating lookup counters; aborted lookups never raise an increment.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (hit_inc_c && hit_cnt_q != '1)   hit_cnt_d  = hit_cnt_q + 32'd1;
      if (miss_inc_c && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   logic unused_perf_c;
   assign unused_perf_c = hit_inc_c ^ miss_inc_c;
`endif

endmodule
